spi_adc7476_rx: RTL and testbench



---
 rtl/spi_adc7476_rx.sv | 132 +++++++++++++
 tb/tb_spi_adc7476_rx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/spi_adc7476_rx.sv
// spi_adc7476_rx: SPI read master for AD7476-class 12-bit ADCs; `define ADC_LEAD_CHK_EN adds err for nonzero leading bits.
module spi_adc7476_rx #(
  parameter int CLK_DIV = 2,
  parameter int QUIET   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st,
  input  logic        SDAT,
  output logic        NCS,
  output logic        SCLK,
  output logic [11:0] DO,
  output logic        ok,
  output logic        busy
`ifdef ADC_LEAD_CHK_EN
  , output logic      err
`endif
);
  localparam logic [7:0] DIV_M = 8'(CLK_DIV - 1);
  localparam logic [7:0] Q_M   = 8'(QUIET - 1);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_QUIET} state_t;
  state_t      r_state, w_state;
  logic [7:0]  r_div, w_div, r_q, w_q;
  logic [5:0]  r_tick, w_tick, w_tn;
  logic [15:0] r_sh, w_sh;
  logic [11:0] r_do, w_do;
  logic        r_ncs, w_ncs, r_sclk, w_sclk, r_ok, w_ok, r_busy, w_busy, w_tk;
`ifdef ADC_LEAD_CHK_EN
  logic        r_err, w_err;
  assign err = r_err;
`endif
  assign w_tk = (r_div == DIV_M);
  assign w_tn = r_tick + 6'd1;
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_q     = r_q;
    w_tick  = r_tick;
    w_sh    = r_sh;
    w_do    = r_do;
    w_ncs   = r_ncs;
    w_sclk  = r_sclk;
    w_ok    = 1'b0;
    w_busy  = r_busy;
`ifdef ADC_LEAD_CHK_EN
    w_err   = r_err;
`endif
    case (r_state)
      S_IDLE: if (st) begin
        w_state = S_SETUP;
        w_ncs   = 1'b0;
        w_busy  = 1'b1;
        w_div   = 8'd0;
        w_tick  = 6'd0;
      end
      S_SETUP: begin
        w_div = w_tk ? 8'd0 : r_div + 8'd1;
        if (w_tk) begin
          w_sclk  = 1'b0;
          w_tick  = 6'd0;
          w_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_div = w_tk ? 8'd0 : r_div + 8'd1;
        // Odd ticks rise and sample, even ticks fall; tick 32 closes the frame.
        if (w_tk) begin
          w_tick = w_tn;
          if (w_tn == 6'd32) begin
            w_ncs   = 1'b1;
            w_sclk  = 1'b1;
            w_do    = r_sh[11:0];
            w_ok    = 1'b1;
            w_q     = 8'd0;
            w_state = S_QUIET;
`ifdef ADC_LEAD_CHK_EN
            w_err   = |r_sh[15:12];
`endif
          end else if (w_tn[0]) begin
            w_sclk = 1'b1;
            w_sh   = {r_sh[14:0], SDAT};
          end else begin
            w_sclk = 1'b0;
          end
        end
      end
      S_QUIET: if (r_q == Q_M) begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end else begin
        w_q = r_q + 8'd1;
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= 8'd0;
      r_q     <= 8'd0;
      r_tick  <= 6'd0;
      r_sh    <= 16'd0;
      r_do    <= 12'd0;
      r_ncs   <= 1'b1;
      r_sclk  <= 1'b1;
      r_ok    <= 1'b0;
      r_busy  <= 1'b0;
`ifdef ADC_LEAD_CHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_q     <= w_q;
      r_tick  <= w_tick;
      r_sh    <= w_sh;
      r_do    <= w_do;
      r_ncs   <= w_ncs;
      r_sclk  <= w_sclk;
      r_ok    <= w_ok;
      r_busy  <= w_busy;
`ifdef ADC_LEAD_CHK_EN
      r_err   <= w_err;
`endif
    end
  end
  assign NCS  = r_ncs;
  assign SCLK = r_sclk;
  assign DO   = r_do;
  assign ok   = r_ok;
  assign busy = r_busy;
endmodule

// File: tb/tb_spi_adc7476_rx.sv
// tb_spi_adc7476_rx: directed vector bench with an AD7476 behavioural data source per instance.
module tb_spi_adc7476_rx;
  localparam int QUIET = 4;
  logic clk = 1'b0, rst_n = 1'b0, st0 = 1'b1, st1 = 1'b1, sdat0 = 1'b0, sdat1 = 1'b0;
  logic ncs0, sclk0, ok0, busy0, ncs1, sclk1, ok1, busy1;
  logic [11:0] do0, do1;
`ifdef ADC_LEAD_CHK_EN
  logic err0, err1;
`endif
  logic [15:0] fr0 = 16'h0, fr1 = 16'h0;
  int bi0 = 15, bi1 = 15, fall0 = 0, fall1 = 0;
  int checks = 0, errors = 0;

  typedef struct {
    bit          sel;
    logic [15:0] frame;
    logic [11:0] exp_do;
    bit          exp_err;
    bit          spur;
  } vec_t;
  vec_t v[7];

  always #5 clk = ~clk;

  spi_adc7476_rx #(.CLK_DIV(2), .QUIET(QUIET)) u0 (
    .clk(clk), .rst_n(rst_n), .st(st0), .SDAT(sdat0), .NCS(ncs0), .SCLK(sclk0),
    .DO(do0), .ok(ok0), .busy(busy0)
`ifdef ADC_LEAD_CHK_EN
    , .err(err0)
`endif
  );
  spi_adc7476_rx #(.CLK_DIV(1), .QUIET(QUIET)) u1 (
    .clk(clk), .rst_n(rst_n), .st(st1), .SDAT(sdat1), .NCS(ncs1), .SCLK(sclk1),
    .DO(do1), .ok(ok1), .busy(busy1)
`ifdef ADC_LEAD_CHK_EN
    , .err(err1)
`endif
  );

  // ADC presents the next frame bit (MSB first) on each falling SCLK while selected.
  always @(negedge sclk0) if (!ncs0) begin
    if (bi0 >= 0) sdat0 = fr0[bi0];
    bi0--;
    fall0++;
  end
  always @(negedge sclk1) if (!ncs1) begin
    if (bi1 >= 0) sdat1 = fr1[bi1];
    bi1--;
    fall1++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " ncs0"}, 32'(ncs0), 1);
    chk({nm, " sclk0"}, 32'(sclk0), 1);
    chk({nm, " do0"}, 32'(do0), 0);
    chk({nm, " ok0"}, 32'(ok0), 0);
    chk({nm, " busy0"}, 32'(busy0), 0);
    chk({nm, " ncs1"}, 32'(ncs1), 1);
    chk({nm, " busy1"}, 32'(busy1), 0);
    chk({nm, " do1"}, 32'(do1), 0);
  endtask

  task automatic do_frame(input int k);
    bit s;
    int cd, n, lat, low, okw, bsy, fl;
    logic [11:0] prev, dmid, dfin;
    s = v[k].sel;
    cd = s ? 1 : 2;
    prev = s ? do1 : do0;
    dmid = 'x;
    if (s) begin fr1 = v[k].frame; bi1 = 15; fall1 = 0; end
    else begin fr0 = v[k].frame; bi0 = 15; fall0 = 0; end
    st0 = !s;
    st1 = s;
    lat = 0; low = 0; okw = 0; bsy = 0; n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      st0 = 1'b0;
      st1 = 1'b0;
      if (v[k].spur && (n == 10 || n == 33 * cd + QUIET)) begin st0 = !s; st1 = s; end
      if (!(s ? busy1 : busy0)) break;
      bsy++;
      if (!(s ? ncs1 : ncs0)) low++;
      if (s ? ok1 : ok0) begin okw++; if (lat == 0) lat = n; end
      if (n == 33 * cd) dmid = s ? do1 : do0;
    end
    st0 = 1'b0;
    st1 = 1'b0;
    fl = s ? fall1 : fall0;
    dfin = s ? do1 : do0;
    chk($sformatf("v%0d done", k), 32'(n < 200), 1);
    chk($sformatf("v%0d ok latency", k), 32'(lat), 32'(1 + 33 * cd));
    chk($sformatf("v%0d ok width", k), 32'(okw), 1);
    chk($sformatf("v%0d ncs low", k), 32'(low), 32'(33 * cd));
    chk($sformatf("v%0d busy cycles", k), 32'(bsy), 32'(33 * cd + QUIET));
    chk($sformatf("v%0d sclk falls", k), 32'(fl), 16);
    chk($sformatf("v%0d do held", k), 32'(dmid), 32'(prev));
    chk($sformatf("v%0d do", k), 32'(dfin), 32'(v[k].exp_do));
`ifdef ADC_LEAD_CHK_EN
    chk($sformatf("v%0d err", k), 32'(s ? err1 : err0), 32'(v[k].exp_err));
`endif
    if (v[k].spur) for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d no queued frame", k), 32'(s ? busy1 : busy0), 0);
    end
  endtask

  initial begin
    int oks;
    v[0] = '{0, 16'h0ABC, 12'hABC, 0, 1};
    v[1] = '{0, 16'h0FFF, 12'hFFF, 0, 0};
    v[2] = '{0, 16'h0001, 12'h001, 0, 0};
    v[3] = '{1, 16'h0555, 12'h555, 0, 0};
    v[4] = '{0, 16'h8123, 12'h123, 1, 0};
    v[5] = '{0, 16'h0123, 12'h123, 0, 0};
    v[6] = '{0, 16'h0F0F, 12'hF0F, 0, 0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset($sformatf("reset c%0d", i));
    end
    rst_n = 1'b1;
    st0 = 1'b0;
    st1 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) do_frame(k);
    fr0 = 16'h0ABC;
    bi0 = 15;
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    repeat (21) @(negedge clk);
    chk("pre-reset ncs", 32'(ncs0), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset ncs", 32'(ncs0), 1);
    chk("midreset sclk", 32'(sclk0), 1);
    chk("midreset busy", 32'(busy0), 0);
    chk("midreset ok", 32'(ok0), 0);
    chk("midreset do", 32'(do0), 0);
    rst_n = 1'b1;
    oks = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ok0 || !ncs0) oks++;
    end
    chk("abandoned frame silent", 32'(oks), 0);
    do_frame(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
